mem_port_arbiter: RTL

- Shares one single-port unified memory between the IF stage (instruction fetch, read-only) and the MEM stage (load/store).
- Registers the winning request, drives the memory-side valid/ready handshake and returns data with a one-cycle ack pulse.
- The pipeline stalls a stage while that stage's request is pending and not yet acked.
- Sits between the core's fetch and data paths and the shared memory model.

---
 rtl/mem_port_arbiter_if.sv | 34 +++
 rtl/mem_port_arbiter.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and memory-side signal bundle for mem_port_arbiter.
// slave is the arbiter's view; master is the pipeline plus memory model driving it.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic [31:0] d_rdata;
  logic        d_ack;

  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_be;
  logic [31:0] m_rdata;
  logic        m_ready;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, m_rdata, m_ready,
    output if_rdata, if_ack, d_rdata, d_ack, m_req, m_we, m_addr, m_wdata, m_be
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, m_rdata, m_ready,
    input  if_rdata, if_ack, d_rdata, d_ack, m_req, m_we, m_addr, m_wdata, m_be
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store onto one memory port; ack arrives >=2 cycles after request.
// Requesters stall until ack; memory stalls via m_ready; a stuck access is aborted after TIMEOUT cycles.
module mem_port_arbiter #(
  parameter int unsigned MAX_DATA_STREAK = 3,
  parameter logic [7:0]  TIMEOUT         = 8'd64
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.slave bus,
  output logic              busy_o,
  output logic              timeout_err_o
);

  typedef enum logic [1:0] {IDLE, ISSUE_I, ISSUE_D, RESP} state_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

  state_t      state_q, state_d;
  logic        m_req_q, m_req_d;
  logic        m_we_q, m_we_d;
  logic [31:0] m_addr_q, m_addr_d;
  logic [31:0] m_wdata_q, m_wdata_d;
  logic [3:0]  m_be_q, m_be_d;
  logic        if_ack_q, if_ack_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic        d_ack_q, d_ack_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic [3:0]  streak_q, streak_d;
  logic [7:0]  tmo_cnt_q, tmo_cnt_d;
  logic        tmo_err_q, tmo_err_d;
  logic        busy_q, busy_d;
  logic        tmo_hit;
  logic        data_wins;

  // The counter holds cycles already spent, so the limit is hit during the TIMEOUT-th issue cycle.
  assign tmo_hit   = (TIMEOUT != 8'd0) && (tmo_cnt_q == (TIMEOUT - 8'd1));
  assign data_wins = bus.d_req && !(bus.if_req && (streak_q == STREAK_MAX));

  always_comb begin
    state_d    = state_q;
    m_req_d    = m_req_q;
    m_we_d     = m_we_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    m_be_d     = m_be_q;
    if_ack_d   = 1'b0;
    if_rdata_d = '0;
    d_ack_d    = 1'b0;
    d_rdata_d  = '0;
    streak_d   = streak_q;
    tmo_cnt_d  = tmo_cnt_q;
    tmo_err_d  = tmo_err_q;

    case (state_q)
      IDLE: begin
        if (data_wins) begin
          state_d   = ISSUE_D;
          m_req_d   = 1'b1;
          m_we_d    = bus.d_we;
          m_addr_d  = bus.d_addr;
          m_wdata_d = bus.d_wdata;
          m_be_d    = bus.d_be;
          tmo_cnt_d = '0;
          if (bus.if_req && (streak_q != 4'hF)) begin
            streak_d = streak_q + 4'd1;
          end
        end else if (bus.if_req) begin
          state_d   = ISSUE_I;
          m_req_d   = 1'b1;
          m_we_d    = 1'b0;
          m_addr_d  = bus.if_addr;
          m_wdata_d = '0;
          m_be_d    = 4'hF;
          tmo_cnt_d = '0;
          streak_d  = '0;
        end
      end
      ISSUE_I, ISSUE_D: begin
        if (bus.m_ready || tmo_hit) begin
          state_d = RESP;
          m_req_d = 1'b0;
          if (state_q == ISSUE_I) begin
            if_ack_d   = 1'b1;
            if_rdata_d = bus.m_ready ? bus.m_rdata : '0;
          end else begin
            d_ack_d   = 1'b1;
            d_rdata_d = (bus.m_ready && !m_we_q) ? bus.m_rdata : '0;
          end
          if (!bus.m_ready) begin
            tmo_err_d = 1'b1;
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      m_be_q     <= '0;
      if_ack_q   <= 1'b0;
      if_rdata_q <= '0;
      d_ack_q    <= 1'b0;
      d_rdata_q  <= '0;
      streak_q   <= '0;
      tmo_cnt_q  <= '0;
      tmo_err_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      m_req_q    <= m_req_d;
      m_we_q     <= m_we_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      m_be_q     <= m_be_d;
      if_ack_q   <= if_ack_d;
      if_rdata_q <= if_rdata_d;
      d_ack_q    <= d_ack_d;
      d_rdata_q  <= d_rdata_d;
      streak_q   <= streak_d;
      tmo_cnt_q  <= tmo_cnt_d;
      tmo_err_q  <= tmo_err_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.m_req    = m_req_q;
  assign bus.m_we     = m_we_q;
  assign bus.m_addr   = m_addr_q;
  assign bus.m_wdata  = m_wdata_q;
  assign bus.m_be     = m_be_q;
  assign bus.if_ack   = if_ack_q;
  assign bus.if_rdata = if_rdata_q;
  assign bus.d_ack    = d_ack_q;
  assign bus.d_rdata  = d_rdata_q;
  assign busy_o       = busy_q;
  assign timeout_err_o = tmo_err_q;

endmodule
